// File: rtl/quad_7seg_capture.sv
// ---------------------------------------------------------------------------
// quad_7seg_capture
//
// Watches a multiplexed 4-digit seven-segment display bus and recovers the
// hex value, glyph validity and decimal point of each digit. A digit is
// captured once its enable and segment pattern have been stable for
// STABLE_CYCLES synchronized samples. When all four digits have been
// captured, the whole frame is published at once.
//
// Parameters
//   STABLE_CYCLES  : identical samples needed before a capture (2..255)
//   SEG_ACTIVE_LOW : 1 = segment/dp lit when its line is 0
//   DIG_ACTIVE_LOW : 1 = digit enabled when its line is 0
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-high reset
//   se7enDriver    in   [7:0] segment bus, bit7 = dp, bits6..0 = g..a
//   digitEnable    in   [3:0] digit enables, bit i = digit i
//   digits         out  [15:0] captured hex values, digit i at [4i+3:4i]
//   digitsValid    out  [3:0] digit i decoded to a legal hex glyph
//   dpOut          out  [3:0] dp of digit i lit
//   frameStrobe    out  one-cycle pulse when digits/digitsValid/dpOut update
//   multiEnableErr out  sticky: more than one digit enabled at once
//   scanTimeout    out  one-cycle pulse when a partial frame is abandoned
//
// Build option
//   QUAD_7SEG_CAPTURE_TIMEOUT_EN : when defined, a 20-bit counter abandons a
//   partial frame that is not completed within 2^20-1 cycles. When undefined
//   the counter is absent and scanTimeout is tied low.
// ---------------------------------------------------------------------------
module quad_7seg_capture #(
  parameter int STABLE_CYCLES  = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  se7enDriver,
  input  logic [3:0]  digitEnable,
  output logic [15:0] digits,
  output logic [3:0]  digitsValid,
  output logic [3:0]  dpOut,
  output logic        frameStrobe,
  output logic        multiEnableErr,
  output logic        scanTimeout
);

  // Pin level that means "nothing lit / nothing enabled".
  localparam logic [7:0] SEG_IDLE   = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [3:0] DIG_IDLE   = (DIG_ACTIVE_LOW != 0) ? 4'hF  : 4'h0;
  localparam logic [7:0] STABLE_TGT = 8'(STABLE_CYCLES);

  // Returns {valid, value} for an active-high g..a pattern.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'h3F:   res = 5'h10;
      7'h06:   res = 5'h11;
      7'h5B:   res = 5'h12;
      7'h4F:   res = 5'h13;
      7'h66:   res = 5'h14;
      7'h6D:   res = 5'h15;
      7'h7D:   res = 5'h16;
      7'h07:   res = 5'h17;
      7'h7F:   res = 5'h18;
      7'h6F:   res = 5'h19;
      7'h77:   res = 5'h1A;
      7'h7C:   res = 5'h1B;
      7'h39:   res = 5'h1C;
      7'h5E:   res = 5'h1D;
      7'h79:   res = 5'h1E;
      7'h71:   res = 5'h1F;
      default: res = 5'h00;
    endcase
    return res;
  endfunction

  // Synchronizer stages (raw pin polarity).
  logic [7:0]  seg_meta_q, seg_meta_d, seg_sync_q, seg_sync_d;
  logic [3:0]  en_meta_q, en_meta_d, en_sync_q, en_sync_d;

  // Previous normalized sample and stability counter.
  logic [7:0]  prev_seg_q, prev_seg_d;
  logic [3:0]  prev_en_q, prev_en_d;
  logic [7:0]  stab_q, stab_d;

  // Holding slots filled one digit at a time.
  logic [15:0] hold_val_q, hold_val_d;
  logic [3:0]  hold_vld_q, hold_vld_d;
  logic [3:0]  hold_dp_q, hold_dp_d;
  logic [3:0]  mask_q, mask_d;

  // Published frame and status outputs.
  logic [15:0] digits_q, digits_d;
  logic [3:0]  digits_valid_q, digits_valid_d;
  logic [3:0]  dp_out_q, dp_out_d;
  logic        frame_strobe_q, frame_strobe_d;
  logic        multi_err_q, multi_err_d;
  logic        scan_timeout_q, scan_timeout_d;

`ifdef QUAD_7SEG_CAPTURE_TIMEOUT_EN
  logic [19:0] tmo_q, tmo_d;
`endif

  // Combinational helpers.
  logic [7:0]  seg_n_s;
  logic [3:0]  en_n_s;
  logic [2:0]  en_cnt_s;
  logic        is_idle_s, is_one_s, is_multi_s, same_s, capture_s, full_s;
  logic [1:0]  k_idx_s;
  logic [4:0]  dec_s;
  logic [3:0]  mask_base_s;

  // Next-state logic for the whole capture path.
  always_comb begin
    seg_meta_d = se7enDriver;
    seg_sync_d = seg_meta_q;
    en_meta_d  = digitEnable;
    en_sync_d  = en_meta_q;

    // Everything past the synchronizer works in active-high terms.
    seg_n_s = (SEG_ACTIVE_LOW != 0) ? ~seg_sync_q : seg_sync_q;
    en_n_s  = (DIG_ACTIVE_LOW != 0) ? ~en_sync_q  : en_sync_q;

    en_cnt_s   = {2'b00, en_n_s[0]} + {2'b00, en_n_s[1]}
               + {2'b00, en_n_s[2]} + {2'b00, en_n_s[3]};
    is_idle_s  = (en_cnt_s == 3'd0);
    is_one_s   = (en_cnt_s == 3'd1);
    is_multi_s = (en_cnt_s >= 3'd2);

    case (en_n_s)
      4'b0001: k_idx_s = 2'd0;
      4'b0010: k_idx_s = 2'd1;
      4'b0100: k_idx_s = 2'd2;
      4'b1000: k_idx_s = 2'd3;
      default: k_idx_s = 2'd0;
    endcase

    same_s     = (seg_n_s == prev_seg_q) && (en_n_s == prev_en_q);
    prev_seg_d = seg_n_s;
    prev_en_d  = en_n_s;

    // Only ONE samples build up stability; IDLE and MULTI restart it.
    if (is_multi_s || is_idle_s) begin
      stab_d = 8'd0;
    end else if (same_s) begin
      stab_d = (stab_q < STABLE_TGT) ? (stab_q + 8'd1) : stab_q;
    end else begin
      stab_d = 8'd1;
    end

    // Capture on the single cycle the counter arrives at the target;
    // saturation keeps it from firing again during the same dwell.
    capture_s = is_one_s && (stab_d == STABLE_TGT) && (stab_q != STABLE_TGT);
    dec_s     = seg_decode(seg_n_s[6:0]);

    multi_err_d = multi_err_q | is_multi_s;

    full_s         = (mask_q == 4'hF);
    digits_d       = digits_q;
    digits_valid_d = digits_valid_q;
    dp_out_d       = dp_out_q;
    frame_strobe_d = 1'b0;
    scan_timeout_d = 1'b0;

    // A full mask publishes the holding slots and starts a new frame.
    if (full_s) begin
      digits_d       = hold_val_q;
      digits_valid_d = hold_vld_q;
      dp_out_d       = hold_dp_q;
      frame_strobe_d = 1'b1;
      mask_base_s    = 4'h0;
    end else begin
      mask_base_s    = mask_q;
    end

`ifdef QUAD_7SEG_CAPTURE_TIMEOUT_EN
    // Abandon a partial frame that has lingered too long.
    if (full_s || (mask_q == 4'h0)) begin
      tmo_d = 20'd0;
    end else if (tmo_q == 20'hFFFFF) begin
      tmo_d          = 20'd0;
      scan_timeout_d = 1'b1;
      mask_base_s    = 4'h0;
    end else begin
      tmo_d = tmo_q + 20'd1;
    end
`endif

    hold_val_d = hold_val_q;
    hold_vld_d = hold_vld_q;
    hold_dp_d  = hold_dp_q;
    mask_d     = mask_base_s;
    // A capture landing in the same cycle as a publish/abandon still counts
    // toward the next frame; the publish copies the old slot contents.
    for (int i = 0; i < 4; i++) begin
      if (capture_s && (k_idx_s == 2'(i))) begin
        hold_val_d[4*i +: 4] = dec_s[3:0];
        hold_vld_d[i]        = dec_s[4];
        hold_dp_d[i]         = seg_n_s[7];
        mask_d[i]            = 1'b1;
      end else begin
        mask_d[i]            = mask_base_s[i];
      end
    end
  end

  // State registers; reset puts the synchronizers at the inactive pin level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_meta_q     <= SEG_IDLE;
      seg_sync_q     <= SEG_IDLE;
      en_meta_q      <= DIG_IDLE;
      en_sync_q      <= DIG_IDLE;
      prev_seg_q     <= 8'h00;
      prev_en_q      <= 4'h0;
      stab_q         <= 8'd0;
      hold_val_q     <= 16'h0000;
      hold_vld_q     <= 4'h0;
      hold_dp_q      <= 4'h0;
      mask_q         <= 4'h0;
      digits_q       <= 16'h0000;
      digits_valid_q <= 4'h0;
      dp_out_q       <= 4'h0;
      frame_strobe_q <= 1'b0;
      multi_err_q    <= 1'b0;
      scan_timeout_q <= 1'b0;
`ifdef QUAD_7SEG_CAPTURE_TIMEOUT_EN
      tmo_q          <= 20'd0;
`endif
    end else begin
      seg_meta_q     <= seg_meta_d;
      seg_sync_q     <= seg_sync_d;
      en_meta_q      <= en_meta_d;
      en_sync_q      <= en_sync_d;
      prev_seg_q     <= prev_seg_d;
      prev_en_q      <= prev_en_d;
      stab_q         <= stab_d;
      hold_val_q     <= hold_val_d;
      hold_vld_q     <= hold_vld_d;
      hold_dp_q      <= hold_dp_d;
      mask_q         <= mask_d;
      digits_q       <= digits_d;
      digits_valid_q <= digits_valid_d;
      dp_out_q       <= dp_out_d;
      frame_strobe_q <= frame_strobe_d;
      multi_err_q    <= multi_err_d;
      scan_timeout_q <= scan_timeout_d;
`ifdef QUAD_7SEG_CAPTURE_TIMEOUT_EN
      tmo_q          <= tmo_d;
`endif
    end
  end

  assign digits         = digits_q;
  assign digitsValid    = digits_valid_q;
  assign dpOut          = dp_out_q;
  assign frameStrobe    = frame_strobe_q;
  assign multiEnableErr = multi_err_q;
  assign scanTimeout    = scan_timeout_q;

endmodule

// File: tb/tb_quad_7seg_capture.sv
// Scoreboard bench for quad_7seg_capture with default parameters
// (STABLE_CYCLES=16, active-low segments and digit enables).
module tb_quad_7seg_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  se7enDriver;
  logic [3:0]  digitEnable;
  logic [15:0] digits;
  logic [3:0]  digitsValid;
  logic [3:0]  dpOut;
  logic        frameStrobe;
  logic        multiEnableErr;
  logic        scanTimeout;

  int          total = 0;
  int          bad = 0;
  int          strobe_cnt = 0;
  int          exp_strobes = 0;
  logic        timeout_seen = 1'b0;
  logic [23:0] exp_q[$];
  logic [23:0] exp_item;

  quad_7seg_capture dut (
    .clk            (clk),
    .rst            (rst),
    .se7enDriver    (se7enDriver),
    .digitEnable    (digitEnable),
    .digits         (digits),
    .digitsValid    (digitsValid),
    .dpOut          (dpOut),
    .frameStrobe    (frameStrobe),
    .multiEnableErr (multiEnableErr),
    .scanTimeout    (scanTimeout)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every frame strobe must match the oldest expected frame.
  always @(negedge clk) begin
    if (scanTimeout === 1'b1) timeout_seen = 1'b1;
    if (rst === 1'b0 && frameStrobe === 1'b1) begin
      strobe_cnt++;
      if (exp_q.size() == 0) begin
        check_val("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        exp_item = exp_q.pop_front();
        check_val("frame_digits", {16'h0, digits}, {16'h0, exp_item[23:8]});
        check_val("frame_valid", {28'h0, digitsValid}, {28'h0, exp_item[7:4]});
        check_val("frame_dp", {28'h0, dpOut}, {28'h0, exp_item[3:0]});
      end
    end
  end

  // Show an active-high pattern on digit k (pins are active-low).
  task automatic show(input int k, input logic [7:0] pat, input int cyc);
    se7enDriver = ~pat;
    digitEnable = ~(4'b0001 << k);
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cyc);
    se7enDriver = 8'hFF;
    digitEnable = 4'hF;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for all expected frames to be consumed.
  task automatic drain(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("drain", exp_q.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    se7enDriver = 8'hFF;
    digitEnable = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_digits", {16'h0, digits}, 32'h0);
    check_val("rst_valid", {28'h0, digitsValid}, 32'h0);
    check_val("rst_dp", {28'h0, dpOut}, 32'h0);
    check_val("rst_strobe", {31'h0, frameStrobe}, 32'h0);
    check_val("rst_multi", {31'h0, multiEnableErr}, 32'h0);
    check_val("rst_timeout", {31'h0, scanTimeout}, 32'h0);
    rst = 1'b0;
    idle(5);

    // Basic scan 0,1,2,3.
    exp_q.push_back({16'h3210, 4'hF, 4'h0});
    exp_strobes++;
    show(0, 8'h3F, 40);
    show(1, 8'h06, 40);
    show(2, 8'h5B, 40);
    show(3, 8'h4F, 40);
    idle(5);
    drain(60);
    check_val("strobe_count_1", strobe_cnt, exp_strobes);
    idle(30);
    check_val("hold_1", {16'h0, digits}, 32'h3210);

    // Digit 2 illegal glyph with dp lit.
    exp_q.push_back({16'hC0BA, 4'hB, 4'h4});
    exp_strobes++;
    show(0, 8'h77, 40);
    show(1, 8'h7C, 40);
    show(2, 8'hC9, 40);
    show(3, 8'h39, 40);
    idle(5);
    drain(60);

    // Digit 2 pins all low: every segment and dp lit -> '8' with dp.
    exp_q.push_back({16'hF8ED, 4'hF, 4'h4});
    exp_strobes++;
    show(0, 8'h5E, 40);
    show(1, 8'h79, 40);
    show(2, 8'hFF, 40);
    show(3, 8'h71, 40);
    idle(5);
    drain(60);

    // Glitching digit 1 never becomes stable.
    show(0, 8'h6D, 40);
    for (int i = 0; i < 10; i++) begin
      show(1, 8'h06, 9);
      show(1, 8'h5B, 1);
    end
    check_val("glitch_no_strobe", strobe_cnt, exp_strobes);
    check_val("glitch_hold", {16'h0, digits}, 32'hF8ED);
    exp_q.push_back({16'h7615, 4'hF, 4'h0});
    exp_strobes++;
    show(1, 8'h06, 40);
    show(2, 8'h7D, 40);
    show(3, 8'h07, 40);
    idle(5);
    drain(60);

    // Two enables for one cycle -> sticky error.
    idle(5);
    digitEnable = 4'b1100;
    se7enDriver = 8'hFF;
    @(posedge clk);
    #1;
    idle(6);
    check_val("multi_set", {31'h0, multiEnableErr}, 32'h1);
    exp_q.push_back({16'h1098, 4'hF, 4'h0});
    exp_strobes++;
    show(0, 8'h7F, 40);
    show(1, 8'h6F, 40);
    show(2, 8'h3F, 40);
    show(3, 8'h06, 40);
    idle(5);
    drain(60);
    check_val("multi_sticky", {31'h0, multiEnableErr}, 32'h1);

    // Reset after three captures discards them.
    show(0, 8'h4F, 40);
    show(1, 8'h66, 40);
    show(2, 8'h6D, 40);
    rst = 1'b1;
    idle(2);
    check_val("rst2_digits", {16'h0, digits}, 32'h0);
    check_val("rst2_valid", {28'h0, digitsValid}, 32'h0);
    check_val("rst2_multi", {31'h0, multiEnableErr}, 32'h0);
    rst = 1'b0;
    idle(3);
    show(3, 8'h39, 40);
    idle(20);
    check_val("rst2_no_strobe", strobe_cnt, exp_strobes);
    show(0, 8'h77, 40);
    show(1, 8'h7C, 40);
    check_val("rst2_partial", strobe_cnt, exp_strobes);
    exp_q.push_back({16'hCDBA, 4'hF, 4'h0});
    exp_strobes++;
    show(2, 8'h5E, 40);
    idle(5);
    drain(60);
    check_val("strobe_count_end", strobe_cnt, exp_strobes);
    check_val("scan_timeout_quiet", {31'h0, timeout_seen}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
